// File: rtl/lms_ctr_gpo.sv
// ============================================================================
// Module   : lms_ctr_gpo
// Brief    : Avalon-MM general-purpose output port with DATA/SET/CLEAR
//            registers and a re-triggerable timed one-shot pulse engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lms_ctr_gpo #(
    parameter int          WIDTH        = 8,
    parameter logic [31:0] RESET_VALUE  = 32'h0,
    parameter int          CNT_W        = 16,
    parameter int          PULSE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             pulse_busy
);

    localparam logic [WIDTH-1:0] c_RESET_VALUE  = RESET_VALUE[WIDTH-1:0];
    localparam logic [CNT_W-1:0] c_PULSE_CYCLES = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_ONE      = CNT_W'(1);

    localparam logic [1:0] c_ADDR_DATA  = 2'd0;
    localparam logic [1:0] c_ADDR_SET   = 2'd1;
    localparam logic [1:0] c_ADDR_CLEAR = 2'd2;
    localparam logic [1:0] c_ADDR_PULSE = 2'd3;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_data;
    logic [WIDTH-1:0]  w_data_next;
    logic [WIDTH-1:0]  r_mask;
    logic [WIDTH-1:0]  w_mask_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [31:0]       r_readdata;
    logic [31:0]       w_readdata_next;
    logic [WIDTH-1:0]  r_out;
    logic              r_busy;

    logic              w_wr;
    logic [WIDTH-1:0]  w_wd;
    logic              w_pulse_load;
    logic              w_unused;

    assign w_wr         = chipselect & ~write_n;
    assign w_wd         = writedata[WIDTH-1:0];
    assign w_pulse_load = w_wr && (address == c_ADDR_PULSE) && (w_wd != '0);
    assign w_unused     = ^{1'b0, writedata};

    // Register file write path
    always_comb begin
        w_data_next = r_data;
        if (w_wr) begin
            case (address)
                c_ADDR_DATA:  w_data_next = w_wd;
                c_ADDR_SET:   w_data_next = r_data | w_wd;
                c_ADDR_CLEAR: w_data_next = r_data & ~w_wd;
                default:      w_data_next = r_data;
            endcase
        end
    end

    // Pulse engine; a PULSE write always beats the expiry on the same edge
    always_comb begin
        w_state_next = r_state;
        w_mask_next  = r_mask;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_pulse_load) begin
                    w_state_next = S_ACTIVE;
                    w_mask_next  = r_mask | w_wd;
                    w_cnt_next   = c_PULSE_CYCLES;
                end
            end
            S_ACTIVE: begin
                if (w_pulse_load) begin
                    w_mask_next = r_mask | w_wd;
                    w_cnt_next  = c_PULSE_CYCLES;
                end else if (r_cnt == c_CNT_ONE) begin
                    w_state_next = S_IDLE;
                    w_mask_next  = '0;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt - c_CNT_ONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_mask_next  = '0;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Read mux samples pre-write register values
    always_comb begin
        w_readdata_next = '0;
        if (address == c_ADDR_PULSE) begin
            w_readdata_next[WIDTH-1:0] = r_mask;
        end else begin
            w_readdata_next[WIDTH-1:0] = r_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_data     <= c_RESET_VALUE;
            r_mask     <= '0;
            r_cnt      <= '0;
            r_readdata <= '0;
            r_out      <= c_RESET_VALUE;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_data     <= w_data_next;
            r_mask     <= w_mask_next;
            r_cnt      <= w_cnt_next;
            r_readdata <= w_readdata_next;
            r_out      <= w_data_next | w_mask_next;
            r_busy     <= (w_state_next == S_ACTIVE);
        end
    end

    assign readdata   = r_readdata;
    assign out_port   = r_out;
    assign pulse_busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_lms_ctr_gpo.sv
// ============================================================================
// Module   : tb_lms_ctr_gpo
// Brief    : Self-checking bench for lms_ctr_gpo against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lms_ctr_gpo;

    localparam int          WIDTH = 8;
    localparam logic [31:0] RV    = 32'hA5;
    localparam int          PC    = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic [WIDTH-1:0] out_port;
    logic        pulse_busy;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    // Model state: data value, active pulse bits, cycles of pulse remaining
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] m_mask;
    int               m_left;
    logic [31:0]      m_rd;

    lms_ctr_gpo #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RV),
        .CNT_W       (16),
        .PULSE_CYCLES(PC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .pulse_busy(pulse_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        logic [WIDTH-1:0] wd;
        bit               wr;
        wd = writedata[WIDTH-1:0];
        wr = chipselect && !write_n;
        if (reset) begin
            m_data = RV[WIDTH-1:0];
            m_mask = '0;
            m_left = 0;
            m_rd   = 32'h0;
        end else begin
            m_rd = (address == 2'd3) ? {24'h0, m_mask} : {24'h0, m_data};
            if (wr && address == 2'd0) m_data = wd;
            if (wr && address == 2'd1) m_data = m_data | wd;
            if (wr && address == 2'd2) m_data = m_data & ~wd;
            if (wr && address == 2'd3 && wd != '0) begin
                m_mask = m_mask | wd;
                m_left = PC;
            end else if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) m_mask = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_out",  {24'h0, out_port},   {24'h0, m_data | m_mask});
            chk("model_rd",   readdata,            m_rd);
            chk("model_busy", {31'h0, pulse_busy}, {31'h0, m_left > 0});
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk); #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset
        repeat (3) tick();
        cmp_en = 1'b1;
        chk("rst_out",  {24'h0, out_port}, 32'hA5);
        chk("rst_rd",   readdata, 32'h0);
        chk("rst_busy", {31'h0, pulse_busy}, 32'h0);
        reset = 1'b0;
        tick();
        chk("rd_addr0", readdata, 32'h0000_00A5);

        // DATA / SET / CLEAR
        wr(2'd0, 32'h0F);
        wr(2'd1, 32'hF0);
        chk("set_out", {24'h0, out_port}, 32'hFF);
        wr(2'd2, 32'h3C);
        chk("clr_out", {24'h0, out_port}, 32'hC3);
        for (int a = 0; a < 3; a++) begin
            address = a[1:0];
            tick();
            chk("rd_reg", readdata, 32'hC3);
        end
        wr(2'd0, 32'hFFFF_FF00);
        chk("upper_ignored", {24'h0, out_port}, 32'h00);

        // Single one-shot
        wr(2'd3, 32'h01);
        chk("p1_out0",  {24'h0, out_port}, 32'h01);
        chk("p1_busy0", {31'h0, pulse_busy}, 32'h1);
        repeat (3) begin
            tick();
            chk("p1_out", {24'h0, out_port}, 32'h01);
            chk("p1_rd",  readdata, 32'h01);
        end
        tick();
        chk("p1_end_out",  {24'h0, out_port}, 32'h00);
        chk("p1_end_busy", {31'h0, pulse_busy}, 32'h0);
        tick();
        chk("p1_end_rd", readdata, 32'h00);

        // Re-trigger on the expiry cycle
        wr(2'd3, 32'h01);
        repeat (3) tick();
        wr(2'd3, 32'h02);
        chk("rt_out0", {24'h0, out_port}, 32'h03);
        tick();
        chk("rt_rd", readdata, 32'h03);
        repeat (2) begin
            tick();
            chk("rt_out", {24'h0, out_port}, 32'h03);
        end
        tick();
        chk("rt_end", {24'h0, out_port}, 32'h00);

        // DATA write overlapping a pulse
        wr(2'd3, 32'h04);
        wr(2'd0, 32'h04);
        repeat (4) tick();
        chk("ov_out",  {24'h0, out_port}, 32'h04);
        chk("ov_busy", {31'h0, pulse_busy}, 32'h0);
        wr(2'd2, 32'h04);
        chk("ov_clr", {24'h0, out_port}, 32'h00);

        // Reset mid-pulse, with a write attempted under reset
        wr(2'd3, 32'h10);
        tick();
        reset      = 1'b1;
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 2'd0;
        writedata  = 32'h55;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        chk("mrst_out",  {24'h0, out_port}, 32'hA5);
        chk("mrst_busy", {31'h0, pulse_busy}, 32'h0);
        reset   = 1'b0;
        address = 2'd3;
        tick();
        chk("mrst_mask", readdata, 32'h0);

        // Unqualified writes
        address   = 2'd0;
        writedata = 32'h00;
        write_n   = 1'b0;
        tick();
        chk("cs0_out", {24'h0, out_port}, 32'hA5);
        write_n    = 1'b1;
        chipselect = 1'b1;
        tick();
        chk("wn1_out", {24'h0, out_port}, 32'hA5);
        chipselect = 1'b0;
        tick();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
